// File: rtl/commit_trace_fifo_if.sv
// Commit/trace bundle for commit_trace_fifo.
//   commit0_* : older retiring instruction (valid, pc, instr)
//   commit1_* : younger retiring instruction (valid, pc, instr)
//   trace_*   : in-order replay stream (valid/ready handshake, pc, instr)
// master = commit stage + trace consumer side, slave = the FIFO itself.
interface commit_trace_fifo_if;
  logic        commit0_valid;
  logic [31:0] commit0_pc;
  logic [31:0] commit0_instr;
  logic        commit1_valid;
  logic [31:0] commit1_pc;
  logic [31:0] commit1_instr;
  logic        trace_ready;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;

  modport master (
    output commit0_valid, commit0_pc, commit0_instr,
    output commit1_valid, commit1_pc, commit1_instr,
    output trace_ready,
    input  trace_valid, trace_pc, trace_instr
  );

  modport slave (
    input  commit0_valid, commit0_pc, commit0_instr,
    input  commit1_valid, commit1_pc, commit1_instr,
    input  trace_ready,
    output trace_valid, trace_pc, trace_instr
  );
endinterface

// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: buffers up to two retired instructions per cycle and
// replays them one per cycle, oldest first. The CPU is never stalled;
// commits that do not fit are dropped and counted.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   flush         : synchronous empty (pending commits discarded, not counted)
//   clr_stat      : synchronous clear of overflow/drop_cnt
//   bus           : commit slots in, trace stream out (slave modport)
//   fifo_count    : occupied entries (0..DEPTH)
//   overflow      : sticky flag, at least one commit dropped
//   drop_cnt      : saturating count of dropped commits
module commit_trace_fifo #(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  parameter  int unsigned DROP_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  clr_stat,
  commit_trace_fifo_if.slave    bus,
  output logic [PTR_W:0]        fifo_count,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [63:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_p1;
  logic [PTR_W:0]    count_q, count_d;
  logic [PTR_W:0]    free;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DROP_W:0]   drop_sum;
  logic [1:0]        n_req, n_wr, n_drop;
  logic              pop, we0, we1;
  logic [63:0]       wdata0, wdata1, head;

  always_comb begin
    // Free space is sampled before any pop: a same-cycle pop never makes room.
    free   = DEPTH_C - count_q;
    n_req  = {1'b0, bus.commit0_valid} + {1'b0, bus.commit1_valid};
    if (free >= (PTR_W+1)'(n_req)) n_wr = n_req;
    else                           n_wr = free[1:0];
    n_drop = n_req - n_wr;
    pop    = (count_q != '0) && bus.trace_ready;

    // Compaction: the first written entry is slot 0 if valid, else slot 1.
    wdata0    = bus.commit0_valid ? {bus.commit0_pc, bus.commit0_instr}
                                  : {bus.commit1_pc, bus.commit1_instr};
    wdata1    = {bus.commit1_pc, bus.commit1_instr};
    we0       = !flush && (n_wr != 2'd0);
    we1       = !flush && (n_wr == 2'd2);
    wr_ptr_p1 = wr_ptr_q + 1'b1;

    wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W+1)'(n_wr) - (PTR_W+1)'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    drop_sum   = {1'b0, drop_q} + (DROP_W+1)'(n_drop);
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clr_stat) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end else if (!flush && (n_drop != 2'd0)) begin
      overflow_d = 1'b1;
      drop_d     = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage has no reset; an empty FIFO masks it at the outputs.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wr_ptr_q]  <= wdata0;
    if (we1) mem_q[wr_ptr_p1] <= wdata1;
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.trace_valid = (count_q != '0);
  assign bus.trace_pc    = bus.trace_valid ? head[63:32] : '0;
  assign bus.trace_instr = bus.trace_valid ? head[31:0]  : '0;
  assign fifo_count      = count_q;
  assign overflow        = overflow_q;
  assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;
  logic        clk;
  logic        resetn;
  logic        flush;
  logic        clr_stat;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_cnt;
  int unsigned n_vec;
  int unsigned n_err;

  commit_trace_fifo_if bus();

  commit_trace_fifo #(.DEPTH(16), .DROP_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .clr_stat   (clr_stat),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_commit(input logic v0, input logic [31:0] pc0, input logic [31:0] i0,
                            input logic v1, input logic [31:0] pc1, input logic [31:0] i1);
    bus.commit0_valid = v0;
    bus.commit0_pc    = pc0;
    bus.commit0_instr = i0;
    bus.commit1_valid = v1;
    bus.commit1_pc    = pc1;
    bus.commit1_instr = i1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    flush = 1'b0;
    clr_stat = 1'b0;
    bus.trace_ready = 1'b0;
    set_commit(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    n_vec++;
    if (bus.trace_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", bus.trace_valid); end
    n_vec++;
    if (bus.trace_pc !== 32'h0 || bus.trace_instr !== 32'h0) begin
      n_err++; $display("FAIL reset_head got pc=%h instr=%h exp 0/0", bus.trace_pc, bus.trace_instr);
    end
    n_vec++;
    if (fifo_count !== 5'd0 || overflow !== 1'b0 || drop_cnt !== 16'h0) begin
      n_err++; $display("FAIL reset_stat got cnt=%0d ovf=%0b drop=%h exp 0/0/0", fifo_count, overflow, drop_cnt);
    end
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_stream();
    logic [31:0] pc;
    bus.trace_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pc = 32'hBFC0_0000 + 32'(4 * k);
      set_commit(1'b1, pc, 32'h0000_0013 + 32'(k), 1'b0, '0, '0);
      tick();
      n_vec++;
      if (bus.trace_valid !== 1'b1 || bus.trace_pc !== pc || fifo_count !== 5'd1) begin
        n_err++;
        $display("FAIL single_stream[%0d] got v=%0b pc=%h cnt=%0d exp v=1 pc=%h cnt=1",
                 k, bus.trace_valid, bus.trace_pc, fifo_count, pc);
      end
    end
    set_commit(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    n_vec++;
    if (fifo_count !== 5'd0 || overflow !== 1'b0 || bus.trace_valid !== 1'b0) begin
      n_err++; $display("FAIL single_drain got cnt=%0d ovf=%0b v=%0b exp 0/0/0", fifo_count, overflow, bus.trace_valid);
    end
  endtask

  task automatic test_dual_backpressure();
    logic [31:0] pc;
    bus.trace_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_commit(1'b1, 32'h1000 + 32'(8 * k), 32'hA000_0000 + 32'(2 * k),
                 1'b1, 32'h1004 + 32'(8 * k), 32'hA000_0001 + 32'(2 * k));
      tick();
    end
    set_commit(1'b0, '0, '0, 1'b0, '0, '0);
    n_vec++;
    if (fifo_count !== 5'd6) begin n_err++; $display("FAIL dual_count got=%0d exp=6", fifo_count); end
    tick();
    n_vec++;
    if (bus.trace_pc !== 32'h1000 || fifo_count !== 5'd6) begin
      n_err++; $display("FAIL dual_stall got pc=%h cnt=%0d exp pc=00001000 cnt=6", bus.trace_pc, fifo_count);
    end
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      n_vec++;
      if (bus.trace_valid !== 1'b1 || bus.trace_pc !== pc || bus.trace_instr !== 32'hA000_0000 + 32'(i)) begin
        n_err++;
        $display("FAIL dual_order[%0d] got v=%0b pc=%h instr=%h exp pc=%h instr=%h",
                 i, bus.trace_valid, bus.trace_pc, bus.trace_instr, pc, 32'hA000_0000 + 32'(i));
      end
      tick();
    end
    n_vec++;
    if (bus.trace_valid !== 1'b0 || bus.trace_pc !== 32'h0 || bus.trace_instr !== 32'h0) begin
      n_err++; $display("FAIL dual_empty got v=%0b pc=%h instr=%h exp 0/0/0", bus.trace_valid, bus.trace_pc, bus.trace_instr);
    end
  endtask

  task automatic test_slot1_only();
    bus.trace_ready = 1'b0;
    set_commit(1'b0, 32'hDEAD_0000, 32'hFFFF_FFFF, 1'b1, 32'h2000, 32'h0000_0000);
    tick();
    set_commit(1'b0, '0, '0, 1'b0, '0, '0);
    n_vec++;
    if (fifo_count !== 5'd1 || bus.trace_valid !== 1'b1 || bus.trace_pc !== 32'h2000 || bus.trace_instr !== 32'h0) begin
      n_err++;
      $display("FAIL slot1_only got cnt=%0d v=%0b pc=%h instr=%h exp 1/1/00002000/00000000",
               fifo_count, bus.trace_valid, bus.trace_pc, bus.trace_instr);
    end
    bus.trace_ready = 1'b1;
    tick();
    n_vec++;
    if (fifo_count !== 5'd0) begin n_err++; $display("FAIL slot1_drain got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_full_boundary();
    logic [31:0] pc;
    bus.trace_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      set_commit(1'b1, 32'h3000 + 32'(8 * k), 32'hC000_0000 + 32'(2 * k),
                 1'b1, 32'h3004 + 32'(8 * k), 32'hC000_0001 + 32'(2 * k));
      tick();
    end
    set_commit(1'b1, 32'h3038, 32'hC000_000E, 1'b0, '0, '0);
    tick();
    n_vec++;
    if (fifo_count !== 5'd15 || overflow !== 1'b0) begin
      n_err++; $display("FAIL full_fill15 got cnt=%0d ovf=%0b exp 15/0", fifo_count, overflow);
    end
    set_commit(1'b1, 32'h303C, 32'hC000_000F, 1'b1, 32'h3040, 32'hC000_0010);
    tick();
    n_vec++;
    if (fifo_count !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd1) begin
      n_err++; $display("FAIL full_x0 got cnt=%0d ovf=%0b drop=%0d exp 16/1/1", fifo_count, overflow, drop_cnt);
    end
    bus.trace_ready = 1'b1;
    set_commit(1'b1, 32'h4000, 32'h1, 1'b1, 32'h4004, 32'h2);
    tick();
    set_commit(1'b0, '0, '0, 1'b0, '0, '0);
    n_vec++;
    if (fifo_count !== 5'd15 || drop_cnt !== 16'd3) begin
      n_err++; $display("FAIL full_prepop got cnt=%0d drop=%0d exp 15/3", fifo_count, drop_cnt);
    end
    for (int i = 1; i < 16; i++) begin
      pc = 32'h3000 + 32'(4 * i);
      n_vec++;
      if (bus.trace_pc !== pc || bus.trace_instr !== 32'hC000_0000 + 32'(i)) begin
        n_err++;
        $display("FAIL full_drain[%0d] got pc=%h instr=%h exp pc=%h instr=%h",
                 i, bus.trace_pc, bus.trace_instr, pc, 32'hC000_0000 + 32'(i));
      end
      tick();
    end
    n_vec++;
    if (fifo_count !== 5'd0 || bus.trace_valid !== 1'b0) begin
      n_err++; $display("FAIL full_empty got cnt=%0d v=%0b exp 0/0", fifo_count, bus.trace_valid);
    end
  endtask

  task automatic test_saturation();
    bus.trace_ready = 1'b0;
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    n_vec++;
    if (overflow !== 1'b0 || drop_cnt !== 16'h0) begin
      n_err++; $display("FAIL clr_stat got ovf=%0b drop=%h exp 0/0000", overflow, drop_cnt);
    end
    set_commit(1'b1, 32'h5000, 32'h5, 1'b1, 32'h5004, 32'h6);
    for (int k = 0; k < 8; k++) tick();
    n_vec++;
    if (fifo_count !== 5'd16 || drop_cnt !== 16'h0) begin
      n_err++; $display("FAIL sat_fill got cnt=%0d drop=%h exp 16/0000", fifo_count, drop_cnt);
    end
    for (int k = 0; k < 32767; k++) tick();
    n_vec++;
    if (drop_cnt !== 16'hFFFE || overflow !== 1'b1) begin
      n_err++; $display("FAIL sat_fffe got drop=%h ovf=%0b exp fffe/1", drop_cnt, overflow);
    end
    tick();
    n_vec++;
    if (drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff got=%h exp=ffff", drop_cnt); end
    tick();
    n_vec++;
    if (drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got=%h exp=ffff", drop_cnt); end
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    n_vec++;
    if (overflow !== 1'b0 || drop_cnt !== 16'h0 || fifo_count !== 5'd16) begin
      n_err++; $display("FAIL clr_with_drop got ovf=%0b drop=%h cnt=%0d exp 0/0000/16", overflow, drop_cnt, fifo_count);
    end
  endtask

  task automatic test_flush();
    // Still full with dual commits applied: one genuine drop pair first.
    tick();
    n_vec++;
    if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL flush_predrop got=%0d exp=2", drop_cnt); end
    bus.trace_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if (fifo_count !== 5'd0 || drop_cnt !== 16'd2 || bus.trace_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_full got cnt=%0d drop=%0d v=%0b exp 0/2/0", fifo_count, drop_cnt, bus.trace_valid);
    end
    bus.trace_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    set_commit(1'b1, 32'h6000, 32'h7, 1'b0, '0, '0);
    tick();
    n_vec++;
    if (fifo_count !== 5'd7) begin n_err++; $display("FAIL flush_fill7 got=%0d exp=7", fifo_count); end
    set_commit(1'b1, 32'h7000, 32'h8, 1'b1, 32'h7004, 32'h9);
    bus.trace_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_commit(1'b0, '0, '0, 1'b0, '0, '0);
    n_vec++;
    if (fifo_count !== 5'd0 || bus.trace_valid !== 1'b0 || bus.trace_pc !== 32'h0 || drop_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL flush_mid got cnt=%0d v=%0b pc=%h drop=%0d exp 0/0/00000000/2",
               fifo_count, bus.trace_valid, bus.trace_pc, drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bus.trace_ready = 1'b0;
    set_commit(1'b1, 32'h8000, 32'hA, 1'b1, 32'h8004, 32'hB);
    tick();
    n_vec++;
    if (fifo_count !== 5'd2 || bus.trace_pc !== 32'h8000 || overflow !== 1'b1) begin
      n_err++; $display("FAIL rst_pre got cnt=%0d pc=%h ovf=%0b exp 2/00008000/1", fifo_count, bus.trace_pc, overflow);
    end
    #3;
    resetn = 1'b0;
    #1;
    n_vec++;
    if (bus.trace_valid !== 1'b0 || bus.trace_pc !== 32'h0 || bus.trace_instr !== 32'h0 ||
        fifo_count !== 5'd0 || overflow !== 1'b0 || drop_cnt !== 16'h0) begin
      n_err++;
      $display("FAIL rst_async got v=%0b pc=%h instr=%h cnt=%0d ovf=%0b drop=%h exp all 0",
               bus.trace_valid, bus.trace_pc, bus.trace_instr, fifo_count, overflow, drop_cnt);
    end
    tick();
    resetn = 1'b1;
    set_commit(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    n_vec++;
    if (fifo_count !== 5'd0 || bus.trace_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_after got cnt=%0d v=%0b exp 0/0", fifo_count, bus.trace_valid);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single_stream();
    test_dual_backpressure();
    test_slot1_only();
    test_full_boundary();
    test_saturation();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- Buffers retired instructions from the dual-issue commit stage and replays them one per cycle to the ASCII instruction decoder and trace logger.
- Accepts up to two commits per cycle: slot 0 is older, slot 1 is younger.
- Emits an in-order pc/instr stream under a valid/ready handshake.
- Counts commits it must drop when full. The CPU is never stalled.

Parameters:
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, do not override.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush: empties the FIFO (debug restart)
- clr_stat  in  1  synchronous clear of overflow and drop_cnt
- commit0_valid  in  1  slot 0 (older) retired this cycle
- commit0_pc  in  32  slot 0 PC
- commit0_instr  in  32  slot 0 instruction word
- commit1_valid  in  1  slot 1 (younger) retired this cycle
- commit1_pc  in  32  slot 1 PC
- commit1_instr  in  32  slot 1 instruction word
- trace_ready  in  1  consumer accepts the head entry
- trace_valid  out  1  head entry available
- trace_pc  out  32  head PC; 0 when empty
- trace_instr  out  32  head instruction word; 0 when empty
- fifo_count  out  PTR_W+1  occupied entries
- overflow  out  1  sticky: at least one commit dropped
- drop_cnt  out  DROP_W  number of dropped commits, saturating

Behaviour:
- Reset (resetn=0, asynchronous):
  - Read/write pointers and count are 0.
  - trace_valid=0, trace_pc=0, trace_instr=0.
  - overflow=0, drop_cnt=0.
  - Storage contents are don't-care.
- Write ordering:
  - Valid slots are compacted in age order. Slot 0 is written before slot 1.
  - If only commit1_valid is asserted, it is written as a single entry at wr_ptr.
- Free space:
  - free = DEPTH - count, evaluated at the start of the cycle.
  - A same-cycle pop does NOT free space for that cycle's writes.
  - Writes take at most free entries, oldest first. Excess commits are dropped.
  - Example: both slots valid with free=1 → slot 0 stored, slot 1 dropped.
- Drop accounting:
  - Each dropped commit sets overflow.
  - drop_cnt increases by the number dropped (0, 1 or 2) and saturates at all-ones.
- Pop:
  - Occurs when trace_valid && trace_ready. rd_ptr then advances by 1.
- Head outputs:
  - trace_valid = (count != 0).
  - trace_pc and trace_instr are combinational from the entry at rd_ptr, forced to 0 when empty.
  - Latency: a commit written in cycle N appears at the head from cycle N+1 if the FIFO was empty.
  - The head entry stays stable while trace_valid && !trace_ready.
- Count update: count_next = count + writes - pop, with writes in {0,1,2}. count never exceeds DEPTH.
- Pointer wrap: pointers wrap modulo DEPTH.
- flush:
  - Pointers and count return to 0 next cycle. trace_valid=0 next cycle.
  - flush overrides any same-cycle pop and writes.
  - Commits discarded by flush are NOT counted as drops.
- clr_stat:
  - overflow and drop_cnt return to 0 next cycle.
  - If drops occur in the same cycle as clr_stat, clr_stat wins and those drops are not counted.
  - clr_stat is independent of flush.
- Reset mid-operation: asserting resetn=0 at any time gives the reset state immediately. No partial entries survive.

Test Plan:
- Single-slot stream: 5 cycles of commit0 only, with pc 0xBFC00000 + 4k and trace_ready=1 → trace_pc follows one cycle later, 0xBFC00000…0xBFC00010 in order; fifo_count never exceeds 1; overflow=0.
- Dual commit with backpressure:
  - Stimulus: 3 cycles of both slots valid (pc A0/A1, B0/B1, C0/C1), trace_ready=0.
  - Response: fifo_count=6.
  - Then trace_ready=1: output order is A0, A1, B0, B1, C0, C1 over 6 cycles; then trace_valid=0 and trace_pc=0.
- Slot-1-only commit: commit1_valid=1, commit0_valid=0, instr 0x00000000 → a single entry with that pc; count=1.
- Full boundary, DEPTH=16:
  - Fill to count=15 with trace_ready=0, then one dual commit with pc X0/X1 → X0 stored, count=16, overflow=1, drop_cnt=1.
  - Next dual commit with trace_ready=1 → 0 stored (free computed pre-pop), drop_cnt=3, count=15.
  - Pointer wrap is verified by draining all entries in order.
- Saturation and clear:
  - Set drop_cnt=16'hFFFE, then force 2 drops → drop_cnt=16'hFFFF.
  - Then clr_stat with a simultaneous drop → overflow=0, drop_cnt=0.
- Flush and reset mid-stream:
  - At count=7, assert flush together with a dual commit and trace_ready=1 → next cycle count=0, trace_valid=0, drop_cnt unchanged.
  - Separately, resetn low mid-stream → all outputs 0 asynchronously.
